load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle: request/response handshake from the control unit
// plus the word-addressed data memory port. The slave modport is the LSU side.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads and stores to a word-addressed memory.
// Sub-word stores are read-modify-write. All memory-side outputs are registered.
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned half/word
// accesses with resp_err instead of silently ignoring the low address bits.
module load_store_unit #(
    parameter int unsigned ADDR_W = 16
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e            state_q, state_d;
    logic              we_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [31:0]       mem_wdata_q;

    logic              accept;
    logic              misalign;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    assign accept = bus.req_valid && (state_q == StIdle);

`ifdef LSU_ALIGN_CHECK_EN
    // Flag half accesses on odd bytes and word accesses off a word boundary.
    always_comb begin
        misalign = 1'b0;
        case (bus.req_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = bus.req_addr[0];
            default: misalign = |bus.req_addr[1:0];
        endcase
    end
`else
    // Low address bits are simply ignored by the lane selection below.
    assign misalign = 1'b0;
`endif

    // Lane extraction for loads and lane merge for read-modify-write stores.
    always_comb begin
        byte_sel  = bus.mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel  = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        load_data = bus.mem_rdata;
        merged    = bus.mem_rdata;
        case (size_q)
            2'b00: begin
                load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
                merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_data = {{16{signed_q & half_sel[15]}}, half_sel};
                if (lane_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: begin
                load_data = bus.mem_rdata;
                merged    = wdata_q;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic; word stores skip the read phase.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (misalign)                         state_d = StResp;
                    else if (bus.req_we && bus.req_size[1]) state_d = StWrite;
                    else                                  state_d = StRead;
                end
            end
            StRead:  state_d = we_q ? StWrite : StResp;
            StWrite: state_d = StResp;
            StResp:  if (bus.resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: handshakes decode the state, everything else comes from flops.
    always_comb begin
        bus.req_ready  = (state_q == StIdle);
        bus.resp_valid = (state_q == StResp);
        bus.resp_rdata = resp_rdata_q;
        bus.resp_err   = resp_err_q;
        bus.mem_addr   = mem_addr_q;
        bus.mem_we     = mem_we_q;
        bus.mem_wdata  = mem_wdata_q;
    end

    // Request capture, read-data capture and registered memory controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            wdata_q      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 32'h0;
        end else begin
            mem_we_q <= (state_d == StWrite);
            if (accept) begin
                we_q         <= bus.req_we;
                signed_q     <= bus.req_signed;
                size_q       <= bus.req_size;
                lane_q       <= bus.req_addr[1:0];
                wdata_q      <= bus.req_wdata;
                mem_addr_q   <= bus.req_addr[ADDR_W+1:2];
                resp_rdata_q <= 32'h0;
                resp_err_q   <= misalign;
                if (bus.req_we && bus.req_size[1] && !misalign) mem_wdata_q <= bus.req_wdata;
            end
            if (state_q == StRead) begin
                if (we_q) mem_wdata_q  <= merged;
                else      resp_rdata_q <= load_data;
            end
        end
    end
endmodule
